pga_alarm_manager: RTL and testbench
====================================

PGA_ALARM_MANAGER -- requirements
Module: pga_alarm_manager

Interface
REQ-001 Parameter CONFIRM_COUNT, default 3: consecutive alarm-high samples needed to raise the latched alarm (legal range 1..15).
REQ-002 Parameter HOLD_CYCLES, default 1000: minimum clock cycles the alarm stays latched before an accept is honoured (legal range 1..2^20).
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_sample_valid  input  1  one-cycle strobe; i_pga_alarm is meaningful only when this is high.
REQ-006 i_pga_alarm  input  1  per-sample threshold-exceeded flag from the PGA comparator.
REQ-007 i_accept  input  1  operator acknowledge, level or pulse, sampled every cycle.
REQ-008 o_alarm  output  1  latched earthquake alarm; high only in state ALARM.
REQ-009 o_acked  output  1  high only in state ACKED (acknowledged, shaking still present).
REQ-010 o_state  output  2  state encoding: IDLE=0, CONFIRM=1, ALARM=2, ACKED=3.
REQ-011 o_event_count  output  8  number of ALARM entries since reset, saturating.

Function
REQ-012 All outputs SHALL be decoded from registers; there is no combinational path from any input to any output.
REQ-013 Cycles with i_sample_valid low SHALL NOT change state, the confirm counter, or the stored last level.
REQ-014 The block SHALL store the most recent valid i_pga_alarm in a last-level register, updated on every valid sample in all states.
REQ-015 IDLE: a valid sample with i_pga_alarm=1 SHALL go to ALARM if CONFIRM_COUNT=1, else to CONFIRM with the confirm counter at 1.
REQ-016 CONFIRM: a valid high sample SHALL increment the counter, and SHALL go to ALARM when the incremented value equals CONFIRM_COUNT.
REQ-017 CONFIRM: a valid low sample SHALL return to IDLE and clear the counter; i_accept is ignored in CONFIRM.
REQ-018 Latency: o_alarm SHALL be high in the cycle immediately after the clock edge that samples the confirming sample.
REQ-019 ALARM entry SHALL clear the hold timer, clear the confirm counter, and increment o_event_count, saturating at 255.
REQ-020 ALARM: the hold timer SHALL increment every cycle and saturate at HOLD_CYCLES; it is sized to hold HOLD_CYCLES without overflow.
REQ-021 ALARM: i_accept while the timer is below HOLD_CYCLES SHALL be ignored and SHALL NOT be remembered.
REQ-022 ALARM: i_accept with the timer equal to HOLD_CYCLES SHALL be honoured.
REQ-023 On an honoured accept, the effective level SHALL be i_pga_alarm if i_sample_valid is high in the same cycle, else the stored last level.
REQ-024 On an honoured accept, the next state SHALL be IDLE if the effective level is 0, else ACKED.
REQ-025 ALARM SHALL persist regardless of input level until an accept is honoured; low samples do not clear it.
REQ-026 ACKED: a valid low sample SHALL go to IDLE.
REQ-027 ACKED: valid high samples SHALL keep the state in ACKED, with no re-alarm and no change to o_event_count.
REQ-028 A new event SHALL require a return to IDLE followed by a full CONFIRM_COUNT confirmation.
REQ-029 Simultaneous events in ALARM: an honoured accept SHALL take precedence over the sample; only the effective level of REQ-023 matters.

Reset
REQ-030 Asserting i_rst_n low SHALL immediately force state IDLE and clear the confirm counter, hold timer, last level and o_event_count.
REQ-031 During reset, o_alarm=0, o_acked=0, o_state=0 and o_event_count=0.
REQ-032 Reset asserted mid-operation in any state SHALL abandon that state with no retained alarm.
REQ-033 After reset deassertion, the first valid sample SHALL be evaluated as from IDLE.

Verification (CONFIRM_COUNT=3, HOLD_CYCLES=8)
REQ-034 Confirm path: valid samples 1,1,1 with idle cycles between -> o_alarm rises the cycle after the third sample; o_event_count=1.
REQ-035 Glitch reject: valid samples 1,1,0,1,1 -> o_alarm stays 0; o_state ends in CONFIRM with the counter at 2.
REQ-036 Early accept: accept pulse 3 cycles after ALARM entry, then none -> o_alarm stays 1 indefinitely; an accept at 8+ cycles with last level 0 -> IDLE next cycle.
REQ-037 Ack while shaking: honoured accept with last level 1 -> o_state=3, o_alarm=0; further 1s hold ACKED; first valid 0 -> IDLE; count unchanged.
REQ-038 Simultaneous: honoured accept together with valid sample 0 while last level is 1 -> IDLE, not ACKED.
REQ-039 Saturation and reset: 260 confirmed events -> o_event_count=255; async i_rst_n low mid-ALARM, between clock edges -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/pga_alarm_manager.sv
// PGA earthquake alarm manager.
// Confirms a run of consecutive high PGA samples, latches the alarm for a
// minimum hold time, and then lets an operator accept it. After an accept the
// block either returns to IDLE (shaking has stopped) or parks in ACKED until
// the first low sample arrives. All outputs are decoded from registers only.
module pga_alarm_manager #(
    parameter int CONFIRM_COUNT = 3,
    parameter int HOLD_CYCLES   = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sample_valid,
    input  logic       i_pga_alarm,
    input  logic       i_accept,
    output logic       o_alarm,
    output logic       o_acked,
    output logic [1:0] o_state,
    output logic [7:0] o_event_count
);

    // The hold timer must be able to represent HOLD_CYCLES itself, because it
    // saturates there and the accept check compares against that value.
    localparam int                 TIMER_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [TIMER_W-1:0] HOLD_MAX    = TIMER_W'(HOLD_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [3:0]         CONFIRM_MAX = 4'(CONFIRM_COUNT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_ALARM   = 2'd2;
    localparam logic [1:0] ST_ACKED   = 2'd3;

    logic [1:0]         state_q,  state_d;
    logic [3:0]         cnt_q,    cnt_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic               last_q,   last_d;
    logic [7:0]         events_q, events_d;

    logic               eff_level;
    logic               hold_done;

    // Next-state logic: sample qualification, confirmation, hold and accept.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        last_d   = last_q;
        events_d = events_q;

        // A same-cycle sample is fresher than the stored level, so it wins
        // when deciding where an honoured accept should go.
        eff_level = i_sample_valid ? i_pga_alarm : last_q;
        hold_done = (timer_q == HOLD_MAX);

        if (i_sample_valid) begin
            last_d = i_pga_alarm;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_sample_valid && i_pga_alarm) begin
                    if (CONFIRM_MAX == 4'd1) begin
                        state_d = ST_ALARM;
                    end else begin
                        state_d = ST_CONFIRM;
                        cnt_d   = 4'd1;
                    end
                end
            end
            ST_CONFIRM: begin
                // Accept has no meaning until the alarm is actually latched.
                if (i_sample_valid) begin
                    if (i_pga_alarm) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == CONFIRM_MAX) begin
                            state_d = ST_ALARM;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
            end
            ST_ALARM: begin
                if (!hold_done) begin
                    timer_d = timer_q + TIMER_ONE;
                end
                // Early accepts are dropped, not queued; sample level alone
                // never releases the alarm.
                if (i_accept && hold_done) begin
                    state_d = eff_level ? ST_ACKED : ST_IDLE;
                end
            end
            ST_ACKED: begin
                if (i_sample_valid && !i_pga_alarm) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Alarm entry bookkeeping applies to every path into ALARM.
        if ((state_d == ST_ALARM) && (state_q != ST_ALARM)) begin
            timer_d = '0;
            cnt_d   = 4'd0;
            if (events_q != 8'hFF) begin
                events_d = events_q + 8'd1;
            end
        end
    end

    // State registers with asynchronous clear so reset drops the alarm at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            timer_q  <= '0;
            last_q   <= 1'b0;
            events_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            last_q   <= last_d;
            events_q <= events_d;
        end
    end

    assign o_alarm       = (state_q == ST_ALARM);
    assign o_acked       = (state_q == ST_ACKED);
    assign o_state       = state_q;
    assign o_event_count = events_q;

endmodule

// File: tb/tb_pga_alarm_manager.sv
// Testbench for pga_alarm_manager: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the alarm rules.
module tb_pga_alarm_manager;

    localparam int CC   = 3;
    localparam int HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic       sv;
    logic       pga;
    logic       acc;
    logic       o_alarm;
    logic       o_acked;
    logic [1:0] o_state;
    logic [7:0] o_event_count;

    int checks;
    int errors;

    pga_alarm_manager #(
        .CONFIRM_COUNT(CC),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sample_valid(sv),
        .i_pga_alarm   (pga),
        .i_accept      (acc),
        .o_alarm       (o_alarm),
        .o_acked       (o_acked),
        .o_state       (o_state),
        .o_event_count (o_event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode names, a run length of consecutive highs, the
    // unbounded age of the current alarm, the last seen level, event total.
    int  m_mode;     // 0 idle, 1 confirming, 2 alarm, 3 acked
    int  m_run;
    int  m_age;
    bit  m_last;
    int  m_events;
    int  m_next;
    bit  m_level;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode   = 0;
            m_run    = 0;
            m_age    = 0;
            m_last   = 1'b0;
            m_events = 0;
        end else begin
            m_next  = m_mode;
            m_level = sv ? pga : m_last;
            if (m_mode == 0 || m_mode == 1) begin
                if (sv) begin
                    m_run = pga ? m_run + 1 : 0;
                    if (m_run >= CC)     m_next = 2;
                    else if (m_run > 0)  m_next = 1;
                    else                 m_next = 0;
                end
            end else if (m_mode == 2) begin
                if (acc && m_age >= HOLD) m_next = m_level ? 3 : 0;
                m_age = m_age + 1;
            end else begin
                if (sv && !pga) m_next = 0;
            end
            if (m_next == 2 && m_mode != 2) begin
                m_age    = 0;
                m_run    = 0;
                m_events = (m_events < 255) ? m_events + 1 : 255;
            end
            if (sv) m_last = pga;
            m_mode = m_next;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic compare_model();
        int exp_alarm;
        int exp_acked;
        exp_alarm = (m_mode == 2) ? 1 : 0;
        exp_acked = (m_mode == 3) ? 1 : 0;
        checks++;
        if (int'(o_state) != m_mode || int'(o_alarm) != exp_alarm ||
            int'(o_acked) != exp_acked || int'(o_event_count) != m_events) begin
            errors++;
            $display("FAIL model t=%0t actual state=%0d alarm=%0d acked=%0d cnt=%0d required state=%0d alarm=%0d acked=%0d cnt=%0d",
                     $time, o_state, o_alarm, o_acked, o_event_count,
                     m_mode, exp_alarm, exp_acked, m_events);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge, let the rising edge
    // sample them, then compare at the following falling edge.
    task automatic step(input bit v, input bit p, input bit a);
        sv  = v;
        pga = p;
        acc = a;
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic confirm_burst();
        for (int i = 0; i < CC; i++) step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sv     = 1'b0;
        pga    = 1'b0;
        acc    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", int'(o_state), 0);
        chk("reset_alarm", int'(o_alarm), 0);
        chk("reset_count", int'(o_event_count), 0);
        rst_n = 1'b1;

        // Confirm path with idle gaps between samples.
        step(1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 1'b0);
        idle(1);
        chk("confirm_not_yet", int'(o_alarm), 0);
        step(1'b1, 1'b1, 1'b0);
        chk("confirm_alarm", int'(o_alarm), 1);
        chk("confirm_count", int'(o_event_count), 1);

        // Early accept is dropped; alarm persists through low samples.
        idle(2);
        step(1'b0, 1'b0, 1'b1);
        idle(12);
        chk("early_accept_ignored", int'(o_alarm), 1);
        step(1'b1, 1'b0, 1'b0);
        chk("low_sample_keeps_alarm", int'(o_state), 2);
        step(1'b0, 1'b0, 1'b1);
        chk("accept_low_to_idle", int'(o_state), 0);

        // Accept while still shaking parks in ACKED.
        confirm_burst();
        idle(9);
        step(1'b0, 1'b0, 1'b1);
        chk("ack_state", int'(o_state), 3);
        chk("ack_alarm_off", int'(o_alarm), 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("ack_holds", int'(o_state), 3);
        step(1'b1, 1'b0, 1'b0);
        chk("ack_low_idle", int'(o_state), 0);
        chk("ack_count", int'(o_event_count), 2);

        // Hold boundary, then simultaneous accept and low sample.
        confirm_burst();
        idle(7);
        step(1'b0, 1'b0, 1'b1);
        chk("accept_one_short", int'(o_state), 2);
        step(1'b1, 1'b0, 1'b1);
        chk("simul_to_idle", int'(o_state), 0);

        // Glitch rejection: 1,1,0,1,1 leaves confirmation at two.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("glitch_no_alarm", int'(o_alarm), 0);
        chk("glitch_confirm", int'(o_state), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("confirm_ignores_accept", int'(o_state), 1);
        step(1'b1, 1'b1, 1'b0);
        chk("glitch_third_high", int'(o_state), 2);
        chk("glitch_count", int'(o_event_count), 4);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0));
        end

        // Drive the counter into saturation with complete event cycles.
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        idle(HOLD + 1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 260; e++) begin
            confirm_burst();
            idle(HOLD);
            step(1'b1, 1'b0, 1'b1);
        end
        chk("saturated_count", int'(o_event_count), 255);

        // Asynchronous reset in the middle of a clock period while alarmed.
        confirm_burst();
        chk("pre_reset_alarm", int'(o_alarm), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_alarm", int'(o_alarm), 0);
        chk("async_acked", int'(o_acked), 0);
        chk("async_state", int'(o_state), 0);
        chk("async_count", int'(o_event_count), 0);
        @(negedge clk);
        step(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("post_reset_confirm", int'(o_state), 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
